// File: rtl/sobel_edge_detect.sv
// Pipelined Sobel edge detector: 3x3 window in, |Gx|+|Gy| magnitude and thresholded edge bit out.
// Three register stages after window qualification, with raster tracking and border suppression.
module sobel_edge_detect #(
  parameter int IMG_WIDTH  = 800,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       martrix_wr_en,
  input  logic       sobel_en,
  input  logic [7:0] matrix_p11,
  input  logic [7:0] matrix_p12,
  input  logic [7:0] matrix_p13,
  input  logic [7:0] matrix_p21,
  input  logic [7:0] matrix_p22,
  input  logic [7:0] matrix_p23,
  input  logic [7:0] matrix_p31,
  input  logic [7:0] matrix_p32,
  input  logic [7:0] matrix_p33,
  input  logic [7:0] threshold,
  output logic       edge_valid,
  output logic       edge_bit,
  output logic [7:0] edge_data,
  output logic [7:0] mag_sat,
  output logic       frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic          win_valid;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    thr_q;
  logic          accept, at_origin;
  logic [7:0]    thr_eff;

  logic          v1, border1, last1;
  logic [9:0]    gx_p, gx_n, gy_p, gy_n;
  logic [7:0]    thr1;
  logic          v2, border2, last2;
  logic [9:0]    ax, ay;
  logic [7:0]    thr2;
  logic [10:0]   mag;
  logic          is_edge;

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      win_valid <= 1'b0;
    end else begin
      state     <= state_next;
      win_valid <= martrix_wr_en;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sobel_en)  state_next = RUN;
      RUN:     if (!sobel_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept    = win_valid && sobel_en && (state == RUN);
  assign at_origin = (col == '0) && (row == '0);
  // The frame-start window already uses the freshly sampled threshold
  assign thr_eff   = at_origin ? threshold : thr_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      col   <= '0;
      row   <= '0;
      thr_q <= 8'd40;
    end else if ((state == RUN) && !sobel_en) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_origin) thr_q <= threshold;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      v1 <= 1'b0; border1 <= 1'b0; last1 <= 1'b0; thr1 <= '0;
      gx_p <= '0; gx_n <= '0; gy_p <= '0; gy_n <= '0;
      v2 <= 1'b0; border2 <= 1'b0; last2 <= 1'b0; thr2 <= '0;
      ax <= '0; ay <= '0;
    end else begin
      v1      <= accept;
      border1 <= (col < CW'(2));
      last1   <= (col == COL_LAST) && (row == ROW_LAST);
      thr1    <= thr_eff;
      gx_p    <= wsum(matrix_p13, matrix_p23, matrix_p33);
      gx_n    <= wsum(matrix_p11, matrix_p21, matrix_p31);
      gy_p    <= wsum(matrix_p31, matrix_p32, matrix_p33);
      gy_n    <= wsum(matrix_p11, matrix_p12, matrix_p13);
      v2      <= v1;
      border2 <= border1;
      last2   <= last1;
      thr2    <= thr1;
      ax      <= absdiff(gx_p, gx_n);
      ay      <= absdiff(gy_p, gy_n);
    end
  end

  assign mag     = {1'b0, ax} + {1'b0, ay};
  assign is_edge = mag > {3'b000, thr2};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      edge_valid <= 1'b0;
      edge_bit   <= 1'b0;
      edge_data  <= '0;
      mag_sat    <= '0;
      frame_done <= 1'b0;
    end else begin
      edge_valid <= v2;
      frame_done <= v2 && last2;
      if (v2 && !border2) begin
        edge_bit  <= is_edge;
        edge_data <= {8{is_edge}};
        mag_sat   <= (mag > 11'd255) ? 8'hFF : mag[7:0];
      end else begin
        edge_bit  <= 1'b0;
        edge_data <= '0;
        mag_sat   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Scoreboard bench for sobel_edge_detect on a small 8x4 image.
// Expectations come from a behavioural Sobel/raster model and are popped as edge_valid appears.
module tb_sobel_edge_detect;

  localparam int W = 8;
  localparam int H = 4;

  typedef int win_t [9];
  typedef struct {
    int         cyc;
    logic       bit_e;
    logic [7:0] data;
    logic [7:0] mag;
    logic       fd;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       martrix_wr_en;
  logic       sobel_en;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;
  logic [7:0] threshold;
  logic       edge_valid, edge_bit, frame_done;
  logic [7:0] edge_data, mag_sat;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_count = 0;
  int   m_col = 0;
  int   m_row = 0;
  int   m_thr = 40;
  exp_t sb[$];

  sobel_edge_detect #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .martrix_wr_en(martrix_wr_en), .sobel_en(sobel_en),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
    .threshold(threshold),
    .edge_valid(edge_valid), .edge_bit(edge_bit), .edge_data(edge_data),
    .mag_sat(mag_sat), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_pix(input win_t p);
    matrix_p11 = 8'(p[0]); matrix_p12 = 8'(p[1]); matrix_p13 = 8'(p[2]);
    matrix_p21 = 8'(p[3]); matrix_p22 = 8'(p[4]); matrix_p23 = 8'(p[5]);
    matrix_p31 = 8'(p[6]); matrix_p32 = 8'(p[7]); matrix_p33 = 8'(p[8]);
  endtask

  // Reference model: Sobel in plain integers plus the raster position of the accepted window
  task automatic push_expect(input win_t p);
    exp_t e;
    int gxp, gxn, gyp, gyn, ax, ay, mag;
    if (m_col == 0 && m_row == 0) m_thr = int'(threshold);
    gxp = p[2] + 2 * p[5] + p[8];
    gxn = p[0] + 2 * p[3] + p[6];
    gyp = p[6] + 2 * p[7] + p[8];
    gyn = p[0] + 2 * p[1] + p[2];
    ax  = (gxp > gxn) ? gxp - gxn : gxn - gxp;
    ay  = (gyp > gyn) ? gyp - gyn : gyn - gyp;
    mag = ax + ay;
    e.cyc = cyc + 4;
    e.fd  = (m_col == W - 1) && (m_row == H - 1);
    if (m_col < 2) begin
      e.bit_e = 1'b0; e.data = 8'h00; e.mag = 8'h00;
    end else begin
      e.bit_e = (mag > m_thr);
      e.data  = e.bit_e ? 8'hFF : 8'h00;
      e.mag   = (mag > 255) ? 8'hFF : 8'(mag);
    end
    sb.push_back(e);
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  // The window generator strobes first; its matrix registers hold the window on the following cycle
  task automatic send_window(input win_t p);
    martrix_wr_en = 1'b1;
    push_expect(p);
    @(posedge sys_clk); #1;
    set_pix(p);
    martrix_wr_en = 1'b0;
  endtask

  task automatic restart();
    martrix_wr_en = 1'b0;
    sobel_en = 1'b0;
    repeat (2) @(posedge sys_clk); #1;
    m_col = 0; m_row = 0;
    sobel_en = 1'b1;
    repeat (2) @(posedge sys_clk); #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s drain: %0d outputs still pending, required 0", name, sb.size());
      sb.delete();
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (frame_done) fd_count++;
      n_checks++;
      if (frame_done && !edge_valid) begin
        n_fail++;
        $display("[TB] FAIL frame_done_alone: frame_done=1 edge_valid=0");
      end
      if (edge_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_valid: edge_valid=1 at cycle %0d, no output pending", cyc);
        end else begin
          e = sb.pop_front();
          n_checks += 5;
          if (cyc !== e.cyc) begin
            n_fail++; $display("[TB] FAIL latency: output at cycle %0d, required %0d", cyc, e.cyc);
          end
          if (edge_bit !== e.bit_e) begin
            n_fail++; $display("[TB] FAIL edge_bit: got %0b, required %0b (cycle %0d)", edge_bit, e.bit_e, cyc);
          end
          if (edge_data !== e.data) begin
            n_fail++; $display("[TB] FAIL edge_data: got %02h, required %02h (cycle %0d)", edge_data, e.data, cyc);
          end
          if (mag_sat !== e.mag) begin
            n_fail++; $display("[TB] FAIL mag_sat: got %0d, required %0d (cycle %0d)", mag_sat, e.mag, cyc);
          end
          if (frame_done !== e.fd) begin
            n_fail++; $display("[TB] FAIL frame_done: got %0b, required %0b (cycle %0d)", frame_done, e.fd, cyc);
          end
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({edge_valid, edge_bit, edge_data, mag_sat, frame_done} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL %s: outputs v=%0b b=%0b d=%02h m=%02h fd=%0b, required all 0",
               name, edge_valid, edge_bit, edge_data, mag_sat, frame_done);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero("reset_outputs");
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_flat();
    win_t w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    restart();
    threshold = 8'd40;
    for (int i = 0; i < W; i++) send_window(w);
    drain("flat");
  endtask

  task automatic test_vertical();
    win_t w = '{0, 0, 200, 0, 0, 200, 0, 0, 200};
    restart();
    for (int i = 0; i < W; i++) send_window(w);
    drain("vertical");
  endtask

  task automatic test_threshold();
    win_t w20 = '{0, 0, 20, 0, 0, 0, 0, 0, 0};
    win_t w21 = '{0, 0, 21, 0, 0, 0, 0, 0, 0};
    restart();
    threshold = 8'd40;
    for (int i = 0; i < W; i++) begin
      send_window((i % 2 == 0) ? w20 : w21);
      if (i % 3 == 2) begin
        @(posedge sys_clk); #1;
      end
    end
    drain("threshold");
  endtask

  task automatic test_frame();
    win_t w = '{0, 0, 200, 0, 0, 200, 0, 0, 200};
    restart();
    fd_count = 0;
    for (int i = 0; i < W * H; i++) send_window(w);
    drain("frame");
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL frame_done_count: got %0d pulses, required 1", fd_count);
    end
  endtask

  task automatic test_threshold_frame();
    win_t w = '{0, 0, 21, 0, 0, 0, 0, 0, 0};
    restart();
    threshold = 8'd40;
    fd_count = 0;
    for (int i = 0; i < W * H + W; i++) begin
      if (i == 10) threshold = 8'd255;
      send_window(w);
    end
    drain("threshold_frame");
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL thr_frame_done_count: got %0d pulses, required 1", fd_count);
    end
    threshold = 8'd40;
  endtask

  task automatic test_control();
    win_t w = '{0, 0, 200, 0, 0, 200, 0, 0, 200};
    restart();
    set_pix(w);
    for (int i = 0; i < 10; i++) begin
      martrix_wr_en = 1'b1;
      if (i == 6) sobel_en = 1'b0;
      if (i <= 4) push_expect(w);
      @(posedge sys_clk); #1;
    end
    martrix_wr_en = 1'b0;
    drain("control_drop");
    m_col = 0; m_row = 0;
    sobel_en = 1'b1;
    repeat (2) @(posedge sys_clk); #1;
    for (int i = 0; i < 3; i++) send_window(w);
    drain("control_resume");
  endtask

  task automatic test_reset_midrun();
    win_t w = '{0, 0, 200, 0, 0, 200, 0, 0, 200};
    restart();
    set_pix(w);
    for (int i = 0; i < 6; i++) begin
      martrix_wr_en = 1'b1;
      if (i <= 2) push_expect(w);
      @(posedge sys_clk); #1;
    end
    martrix_wr_en = 1'b0;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_outputs_zero("midrun_reset_outputs");
    repeat (10) @(negedge sys_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL midrun_pre_reset: %0d outputs missing, required 0", sb.size());
      sb.delete();
    end
    m_col = 0; m_row = 0; m_thr = 40;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    martrix_wr_en = 1'b0;
    sobel_en = 1'b0;
    threshold = 8'd40;
    matrix_p11 = '0; matrix_p12 = '0; matrix_p13 = '0;
    matrix_p21 = '0; matrix_p22 = '0; matrix_p23 = '0;
    matrix_p31 = '0; matrix_p32 = '0; matrix_p33 = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_flat();
    test_vertical();
    test_threshold();
    test_frame();
    test_threshold_frame();
    test_control();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
